// File: rtl/wb_sram_pkg.sv
// Shared types for the Wishbone SRAM slave: FSM state encoding and wait-counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_sram_state_e;

    // Wide enough for the largest programmable wait-state count (15).
    localparam int WCNT_W = 4;

endpackage

// File: rtl/wb_if.sv
// 32-bit Wishbone classic-cycle bundle shared by master and slave.
// Latency: n/a (wiring only).
// Backpressure: slave stalls the master by withholding ACK/ERR.
interface wb_if;
    logic [31:0] ADR;
    logic [31:0] DAT_W;
    logic [31:0] DAT_R;
    logic [3:0]  SEL;
    logic        WE;
    logic        CYC;
    logic        STB;
    logic        ACK;
    logic        ERR;

    modport slave  (input  ADR, DAT_W, SEL, WE, CYC, STB,
                    output DAT_R, ACK, ERR);
    modport master (output ADR, DAT_W, SEL, WE, CYC, STB,
                    input  DAT_R, ACK, ERR);
endinterface

// File: rtl/wb_sram_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Latency: read data appears one clock after the address is presented.
// Backpressure: none; accepts an access every cycle.
// Ports: clk; we_i/be_i byte write strobes; addr_i word index; wdat_i write data;
//        rdat_o registered read data (old contents on a same-cycle write).
module wb_sram_ram #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdat_i,
    output logic [31:0]   rdat_o
);

    logic [31:0] mem_q [MEM_WORDS];
    logic [31:0] rdat_q;

    // No reset: RAM contents survive a bus reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i && be_i[b]) begin
                mem_q[addr_i][b*8 +: 8] <= wdat_i[b*8 +: 8];
            end
        end
        rdat_q <= mem_q[addr_i];
    end

    assign rdat_o = rdat_q;

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone classic slave backed by a byte-writable word RAM, programmable wait states.
// Latency: ACK/ERR high 1+WAIT_STATES cycles after capture; one transfer per 2+WAIT_STATES.
// Backpressure: master holds CYC/STB until ACK/ERR; dropping either during WAIT aborts.
// Ports: clk; rst_i async active-high reset; s = wb_if.slave bundle.
// Option: define WB_SRAM_SLAVE_ERR_EN to answer addresses with
//         (ADR & ERR_MASK) == ERR_BASE with ERR (no write, DAT_R = 0).
module wb_sram_slave
    import wb_sram_pkg::*;
#(
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ERR_BASE    = 32'hFFFF_0000,
    parameter logic [31:0] ERR_MASK    = 32'hFFFF_0000
) (
    input  logic clk,
    input  logic rst_i,
    wb_if.slave  s
);

    localparam int AW = $clog2(MEM_WORDS);

    wb_sram_state_e    state_q, state_d;
    logic [WCNT_W-1:0] cnt_q, cnt_d;

    // Request latched at capture.
    logic [AW-1:0] adr_q;
    logic          we_q;
    logic [3:0]    sel_q;
    logic [31:0]   dat_q;
    logic          err_hit_q;

    logic ack_q;
    logic err_q;

    logic req;
    logic cap;
    logic err_hit;
    assign req = s.CYC & s.STB;
    assign cap = (state_q == IDLE) && req;

`ifdef WB_SRAM_SLAVE_ERR_EN
    assign err_hit = ((s.ADR & ERR_MASK) == ERR_BASE);
`else
    logic [31:0] err_cfg_unused;
    logic        adr_unused;
    assign err_hit        = 1'b0;
    assign err_cfg_unused = ERR_BASE ^ ERR_MASK;
    assign adr_unused     = ^{s.ADR[31:AW+2], s.ADR[1:0]};
`endif

    // With zero wait states the RAM access happens on the capture edge itself,
    // so in IDLE the live bus feeds the RAM; afterwards the latched copy does.
    logic          in_idle;
    logic [AW-1:0] op_adr;
    logic          op_we;
    logic [3:0]    op_sel;
    logic [31:0]   op_dat;
    logic          op_err;
    assign in_idle = (state_q == IDLE);
    assign op_adr  = in_idle ? s.ADR[AW+1:2] : adr_q;
    assign op_we   = in_idle ? s.WE          : we_q;
    assign op_sel  = in_idle ? s.SEL         : sel_q;
    assign op_dat  = in_idle ? s.DAT_W       : dat_q;
    assign op_err  = in_idle ? err_hit       : err_hit_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d   = WCNT_W'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                // Abort takes priority over finishing the wait.
                if (!req) begin
                    state_d = IDLE;
                end else if (cnt_q == WCNT_W'(1)) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - WCNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The edge entering RESP commits the write and loads the read register.
    // rst_i gating keeps a request held during reset from writing.
    logic enter_resp;
    logic ram_we;
    assign enter_resp = (state_d == RESP);
    assign ram_we     = enter_resp & op_we & ~op_err & ~rst_i;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            adr_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            dat_q     <= '0;
            err_hit_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cap) begin
                adr_q     <= s.ADR[AW+1:2];
                we_q      <= s.WE;
                sel_q     <= s.SEL;
                dat_q     <= s.DAT_W;
                err_hit_q <= err_hit;
            end
            ack_q <= enter_resp & ~op_err;
            err_q <= enter_resp &  op_err;
        end
    end

    logic [31:0] ram_rdat;

    wb_sram_ram #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_ram (
        .clk    (clk),
        .we_i   (ram_we),
        .be_i   (op_sel),
        .addr_i (op_adr),
        .wdat_i (op_dat),
        .rdat_o (ram_rdat)
    );

    // Read data is only exposed alongside ACK, so reset and ERR both show zero.
    assign s.ACK   = ack_q;
    assign s.ERR   = err_q;
    assign s.DAT_R = ack_q ? ram_rdat : 32'h0;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave: three instances with 0, 3 and 5 wait states.
// Read expectations come from a per-instance memory model through a queue.
// ACK/ERR pulse width and exclusivity are watched continuously.
module tb_wb_sram_slave;

`ifdef WB_SRAM_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst;
    logic [2:0]  cyc, stb, we;
    logic [3:0]  sel   [3];
    logic [31:0] adr   [3];
    logic [31:0] dat_w [3];
    wire  [2:0]  ack, err;
    wire  [31:0] dat_r [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_if bus ();
        assign bus.CYC   = cyc[g];
        assign bus.STB   = stb[g];
        assign bus.WE    = we[g];
        assign bus.SEL   = sel[g];
        assign bus.ADR   = adr[g];
        assign bus.DAT_W = dat_w[g];
        assign ack[g]    = bus.ACK;
        assign err[g]    = bus.ERR;
        assign dat_r[g]  = bus.DAT_R;

        wb_sram_slave #(
            .MEM_WORDS   (1024),
            .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 3 : 5)
        ) u_dut (
            .clk   (clk),
            .rst_i (rst[g]),
            .s     (bus)
        );
    end

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [31:0] mdl [3][1024];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // ACK and ERR must be single-cycle pulses and never coincide.
    int         pulse_viol = 0;
    logic [2:0] ack_prev = '0, err_prev = '0;
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if ((ack[d] && ack_prev[d]) || (err[d] && err_prev[d]) || (ack[d] && err[d]))
                pulse_viol++;
        end
        ack_prev = ack;
        err_prev = err;
    end

    // Called at a negedge. Returns latency in cycles from drive to response.
    // keep=1 leaves CYC/STB asserted so the next call forms a back-to-back stream.
    task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] sl, input bit exp_err, input bit keep,
                        output int lat, output logic [31:0] rd);
        int          idx;
        logic [31:0] expv;
        idx = int'(a[11:2]);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dat_w[d] = wd; sel[d] = sl;
        if (!w) begin
            exp_q.push_back(exp_err ? 32'h0 : mdl[d][idx]);
        end else if (!exp_err) begin
            for (int b = 0; b < 4; b++)
                if (sl[b]) mdl[d][idx][b*8 +: 8] = wd[b*8 +: 8];
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack[d] && !err[d] && lat < 50);
        rd = dat_r[d];
        check("resp_seen", 32'(ack[d] | err[d]), 32'h1);
        check("resp_is_err", 32'(err[d]), 32'(exp_err));
        if (!w) begin
            expv = exp_q.pop_front();
            check("rdata", rd, expv);
        end
        if (!keep) begin
            cyc[d] = 1'b0; stb[d] = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, tot, seen;
        logic [31:0] rd;

        rst = 3'b111; cyc = '0; stb = '0; we = '0;
        for (int d = 0; d < 3; d++) begin
            sel[d] = '0; adr[d] = '0; dat_w[d] = '0;
        end
        @(negedge clk); @(negedge clk);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        for (int d = 0; d < 3; d++) check("rst_dat_r", dat_r[d], 32'h0);
        rst = 3'b000;
        @(negedge clk);

        // Zero wait states: write then read back.
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, lat, rd);
        check("ws0_wr_lat", lat, 1);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, lat, rd);
        check("ws0_rd_lat", lat, 1);
        check("ws0_rd_const", rd, 32'hDEADBEEF);

        // Byte lanes.
        xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 1'b0, lat, rd);
        xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, lat, rd);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'h1, 1'b0, 1'b0, lat, rd);
        check("lanes_const", rd, 32'h11BB33DD);

        // Error window: 0xFFFF_0004 aliases onto word 1.
        xfer(0, 1'b1, 32'h4, 32'h01020304, 4'hF, 1'b0, 1'b0, lat, rd);
        xfer(0, 1'b1, 32'hFFFF_0004, 32'h5A5A5A5A, 4'hF, ERR_EN, 1'b0, lat, rd);
        check("errwin_lat", lat, 1);
        xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 1'b0, lat, rd);
        check("errwin_word1", rd, ERR_EN ? 32'h01020304 : 32'h5A5A5A5A);

        // Three wait states: preload, then 8 back-to-back reads.
        for (int i = 0; i < 8; i++)
            xfer(1, 1'b1, 32'h100 + 32'(4*i), 32'hA5000000 ^ (32'h01010101 * 32'(i)),
                 4'hF, 1'b0, 1'b0, lat, rd);
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            xfer(1, 1'b0, 32'h100 + 32'(4*i), 32'h0, 4'hF, 1'b0, (i != 7), lat, rd);
            // First: capture edge + 3 waits; later ones also spend the post-ACK IDLE cycle.
            check("ws3_lat", lat, (i == 0) ? 4 : 5);
            tot += lat;
        end
        // Drive to final ACK; the closing IDLE cycle completes 8 x 5 = 40.
        check("ws3_total", tot, 39);

        // Reset during WAIT drops the pending write.
        xfer(1, 1'b1, 32'h40, 32'h13579BDF, 4'hF, 1'b0, 1'b0, lat, rd);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h40;
        dat_w[1] = 32'hFFFFFFFF; sel[1] = 4'hF;
        @(negedge clk); @(negedge clk);
        rst[1] = 1'b1;
        #1;
        check("rstwait_ack", 32'(ack[1]), 32'h0);
        check("rstwait_err", 32'(err[1]), 32'h0);
        check("rstwait_dat_r", dat_r[1], 32'h0);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b0;
        @(negedge clk);
        xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b0, lat, rd);
        check("rstwait_word", rd, 32'h13579BDF);
        check("rstwait_lat_after", lat, 4);

        // Reset while ACK is high clears the outputs at once.
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h40;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack[1] && lat < 50);
        check("rstresp_ack_seen", 32'(ack[1]), 32'h1);
        rst[1] = 1'b1;
        #1;
        check("rstresp_ack", 32'(ack[1]), 32'h0);
        check("rstresp_dat_r", dat_r[1], 32'h0);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b0;
        @(negedge clk);

        // Five wait states: abort a write by dropping STB in WAIT.
        xfer(2, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, lat, rd);
        check("ws5_lat", lat, 6);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h30;
        dat_w[2] = 32'h0BADBEEF; sel[2] = 4'hF;
        @(negedge clk); @(negedge clk);
        stb[2] = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ack[2] || err[2]) seen++;
        end
        check("abort_no_resp", seen, 0);
        cyc[2] = 1'b0;
        @(negedge clk);
        xfer(2, 1'b0, 32'h30, 32'h0, 4'hF, 1'b0, 1'b0, lat, rd);
        check("abort_word", rd, 32'hCAFEF00D);

        check("pulse_rules", pulse_viol, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_sram_slave.md
# wb_sram_slave

Synthesizable Wishbone classic-cycle slave that responds to the DMA engine's master ports (`wb0m`/`wb1m`). It backs each port with a byte-addressable word RAM, supports programmable wait states, and can optionally inject bus errors. It serves as the source/destination memory in DMA subsystem benches and FPGA bring-up.

## Interface
- `MEM_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `WAIT_STATES`, 0: cycles inserted between request capture and response; 0–15.
- `ERR_BASE`, 32'hFFFF_0000: error-window match value; used only with the macro.
- `ERR_MASK`, 32'hFFFF_0000: error-window address mask; used only with the macro.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `s`  `wb_if.slave`  —  32-bit Wishbone bundle (`ADR`, `DAT_W`, `DAT_R`, `SEL[3:0]`, `WE`, `CYC`, `STB`, `ACK`, `ERR`).

## Operation
- Word index = `ADR[$clog2(MEM_WORDS)+1:2]`. Higher bits are ignored, so the RAM aliases across the address space. `ADR[1:0]` is ignored.
- FSM states:
  - IDLE: on `CYC&STB`, latch `ADR`/`WE`/`SEL`/`DAT_W`. Load the wait counter with `WAIT_STATES`. Go to WAIT if `WAIT_STATES>0`, else RESP.
  - WAIT: decrement the counter each cycle. Go to RESP when the counter reaches 1.
  - RESP: drive `ACK` (or `ERR`) for exactly one cycle, then return to IDLE.
- Write: commits on the clock edge that enters RESP. Only bytes with `SEL[i]=1` are written; other bytes are preserved.
- Read: `DAT_R` is valid for the whole RESP cycle and carries the full word regardless of `SEL`.
- Abort: if `CYC` or `STB` drops in WAIT, return to IDLE with no write and no `ACK`/`ERR`.
- Back-to-back: no acceptance in RESP, so a new request is captured at the earliest in the IDLE cycle after `ACK`.
- `ACK` and `ERR` are never asserted together. Neither is asserted outside RESP.
- Reset mid-transfer: FSM goes to IDLE immediately and any pending write is dropped. RAM contents are not reset.

## Timing
- Reset values: `ACK`=0, `ERR`=0, `DAT_R`=0, FSM=IDLE, wait counter=0.
- Latency from request capture (edge N) to `ACK` high: `1+WAIT_STATES` cycles. `ACK` is high in the cycle after edge `N+WAIT_STATES`.
- Sustained throughput: one transfer per `2+WAIT_STATES` cycles.
- All outputs are registered. There is no combinational path from `s` inputs to `ACK`/`ERR`/`DAT_R`.
- Request inputs are sampled only in IDLE. Changes during WAIT are ignored, except for the `CYC`/`STB` abort.

## Configuration
- Macro: `WB_SRAM_SLAVE_ERR_EN`.
- Defined: a latched address with `(ADR & ERR_MASK)==ERR_BASE` gets `ERR` instead of `ACK` in RESP. For such a transfer the write is suppressed and `DAT_R`=0. Wait-state timing is unchanged.
- Undefined: no comparator is built. `ERR` is tied to 0 and every address gets `ACK`.

## Structure
- Package `wb_sram_pkg`:
  - `typedef enum logic [1:0] {IDLE, WAIT, RESP} wb_sram_state_e`.
  - Wait-counter width constant (4 bits).
- Sub-module `wb_sram_ram`:
  - Single-port RAM of `MEM_WORDS` 32-bit words.
  - 4-bit byte write enable, synchronous write, registered read.
  - The FSM issues the read address on entry to the last pre-RESP cycle so read data lands in RESP.

## Test plan
- Reset: assert `rst_i` mid-WAIT with `WAIT_STATES`=3. `ACK`/`ERR`/`DAT_R` go to 0 immediately and the target word is unchanged.
- Write then read, `WAIT_STATES`=0:
  - Write 32'hDEADBEEF to 0x10 with `SEL`=4'hF; `ACK` is high 1 cycle after capture.
  - Read 0x10: `DAT_R`=32'hDEADBEEF in the `ACK` cycle.
- Byte lanes: preload 0x20=32'h11223344, write 32'hAABBCCDD with `SEL`=4'b0101. A read returns 32'h11BB33DD.
- Wait states, `WAIT_STATES`=3: 8 back-to-back reads. Each `ACK` comes 4 cycles after capture, the 8 transfers take 40 cycles, and every `ACK` is a one-cycle pulse.
- Abort: `WAIT_STATES`=5, write 0x30, drop `STB` after 2 cycles. No `ACK`/`ERR` appears and 0x30 keeps its old value.
- Error window with `WB_SRAM_SLAVE_ERR_EN`: write to 0xFFFF_0004.
  - `ERR` is high for one cycle and `ACK` stays low.
  - The aliased word index 1 is unchanged.
  - Without the macro, the same write gets `ACK` and updates word 1.
